// File: rtl/ps2_keyboard_pkg.sv
// ----------------------------------------------------------------------------
// ps2_keyboard_pkg
// Shared definitions for the PS/2 keyboard receiver:
//   - scan-code set 2 prefix and shift constants
//   - receive FSM state encoding
//   - ASCII constants for the non-printing keys the lookup produces
//   - helper that forms a letter's ASCII code from its alphabet index
// ----------------------------------------------------------------------------
package ps2_keyboard_pkg;

  // Scan-code set 2 prefixes and shift keys
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;

  // ASCII codes produced by the lookup
  localparam logic [7:0] ASCII_CR  = 8'h0D;
  localparam logic [7:0] ASCII_BS  = 8'h08;
  localparam logic [7:0] ASCII_SP  = 8'h20;
  localparam logic [7:0] ASCII_NUL = 8'h00;

  // Receive FSM states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  // Alphabet index 0..25 -> 'a'..'z', or 'A'..'Z' when shift is held
  function automatic logic [7:0] letter_ascii(input logic [4:0] idx,
                                              input logic       shift);
    letter_ascii = (shift ? 8'h41 : 8'h61) + {3'b000, idx};
  endfunction

endpackage

// File: rtl/ps2_scan_to_ascii.sv
// ----------------------------------------------------------------------------
// ps2_scan_to_ascii
// Combinational translation of a scan-code set 2 make code to ASCII.
// Letters honour shift, digits are unshifted, plus space, enter and
// backspace. Any code outside the table yields 0x00.
// Ports:
//   i_scan  [7:0]  make code
//   i_shift        shift key currently held
//   o_ascii [7:0]  ASCII code, 0x00 when the key has no mapping
// ----------------------------------------------------------------------------
module ps2_scan_to_ascii
  import ps2_keyboard_pkg::*;
(
  input  logic [7:0] i_scan,
  input  logic       i_shift,
  output logic [7:0] o_ascii
);

  logic [4:0] w_idx;
  logic       w_is_letter;

  // NOTE: every output of a combinational block is given a default first, so
  // no path through the case statements leaves a value held (no latch).
  always_comb begin
    w_idx       = 5'd0;
    w_is_letter = 1'b1;
    o_ascii     = ASCII_NUL;
    case (i_scan)
      8'h1C: w_idx = 5'd0;   // a
      8'h32: w_idx = 5'd1;   // b
      8'h21: w_idx = 5'd2;   // c
      8'h23: w_idx = 5'd3;   // d
      8'h24: w_idx = 5'd4;   // e
      8'h2B: w_idx = 5'd5;   // f
      8'h34: w_idx = 5'd6;   // g
      8'h33: w_idx = 5'd7;   // h
      8'h43: w_idx = 5'd8;   // i
      8'h3B: w_idx = 5'd9;   // j
      8'h42: w_idx = 5'd10;  // k
      8'h4B: w_idx = 5'd11;  // l
      8'h3A: w_idx = 5'd12;  // m
      8'h31: w_idx = 5'd13;  // n
      8'h44: w_idx = 5'd14;  // o
      8'h4D: w_idx = 5'd15;  // p
      8'h15: w_idx = 5'd16;  // q
      8'h2D: w_idx = 5'd17;  // r
      8'h1B: w_idx = 5'd18;  // s
      8'h2C: w_idx = 5'd19;  // t
      8'h3C: w_idx = 5'd20;  // u
      8'h2A: w_idx = 5'd21;  // v
      8'h1D: w_idx = 5'd22;  // w
      8'h22: w_idx = 5'd23;  // x
      8'h35: w_idx = 5'd24;  // y
      8'h1A: w_idx = 5'd25;  // z
      default: begin
        w_is_letter = 1'b0;
        case (i_scan)
          8'h45:   o_ascii = 8'h30;  // 0
          8'h16:   o_ascii = 8'h31;  // 1
          8'h1E:   o_ascii = 8'h32;  // 2
          8'h26:   o_ascii = 8'h33;  // 3
          8'h25:   o_ascii = 8'h34;  // 4
          8'h2E:   o_ascii = 8'h35;  // 5
          8'h36:   o_ascii = 8'h36;  // 6
          8'h3D:   o_ascii = 8'h37;  // 7
          8'h3E:   o_ascii = 8'h38;  // 8
          8'h46:   o_ascii = 8'h39;  // 9
          8'h29:   o_ascii = ASCII_SP;
          8'h5A:   o_ascii = ASCII_CR;
          8'h66:   o_ascii = ASCII_BS;
          default: o_ascii = ASCII_NUL;
        endcase
      end
    endcase
    if (w_is_letter) o_ascii = letter_ascii(w_idx, i_shift);
  end

endmodule

// File: rtl/ps2_keyboard.sv
// ----------------------------------------------------------------------------
// ps2_keyboard
// PS/2 keyboard receiver: synchronises and de-glitches the raw keyboard
// lines, deserialises 11-bit frames, tracks break/extended/shift state,
// translates make codes to ASCII and queues them for the CPU.
// Ports:
//   clock             50 MHz system clock
//   reset             asynchronous active-low reset
//   ps2_clk           raw keyboard clock (asynchronous)
//   ps2_data          raw keyboard data (asynchronous)
//   key_rd            one-cycle pop strobe from the CPU
//   bus_keyboard[7:0] ASCII at the queue head, 0x00 when empty
//   key_valid         queue non-empty
//   parity_err        one-cycle pulse on a frame dropped for parity/stop
//   overflow          sticky, a key was lost to a full queue
// ----------------------------------------------------------------------------
module ps2_keyboard
  import ps2_keyboard_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       key_rd,
  output logic [7:0] bus_keyboard,
  output logic       key_valid,
  output logic       parity_err,
  output logic       overflow
);

  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  // --------------------------------------------------------------------------
  // Input conditioning: bit 0 = ps2_clk, bit 1 = ps2_data. Lines idle high.
  // --------------------------------------------------------------------------
  logic [1:0]    r_sync1, r_sync2, r_filt;
  logic [FW-1:0] r_fcnt [2];
  logic          r_clk_filt_d;
  logic          w_fall;

  // NOTE: state is only ever updated with non-blocking assignments so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync1      <= 2'b11;
      r_sync2      <= 2'b11;
      r_filt       <= 2'b11;
      r_clk_filt_d <= 1'b1;
      for (int i = 0; i < 2; i++) r_fcnt[i] <= '0;
    end else begin
      r_sync1      <= {ps2_data, ps2_clk};
      r_sync2      <= r_sync1;
      r_clk_filt_d <= r_filt[0];
      // A new level is accepted after FILTER_LEN consecutive disagreeing
      // samples; any agreeing sample restarts the count.
      for (int i = 0; i < 2; i++) begin
        if (r_sync2[i] == r_filt[i]) begin
          r_fcnt[i] <= '0;
        end else if (r_fcnt[i] == FW'(FILTER_LEN - 1)) begin
          r_filt[i] <= r_sync2[i];
          r_fcnt[i] <= '0;
        end else begin
          r_fcnt[i] <= r_fcnt[i] + FW'(1);
        end
      end
    end
  end

  // One-cycle strobe in the cycle after the filtered clock fell; the FSM acts
  // on it at the following edge, sampling the filtered data line.
  assign w_fall = r_clk_filt_d & ~r_filt[0];

  // --------------------------------------------------------------------------
  // Frame receive FSM
  // --------------------------------------------------------------------------
  ps2_state_e r_state, w_state_nxt;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_sreg;
  logic          r_parity;
  logic [TW-1:0] r_to_cnt;
  logic          w_data_bit, w_timeout, w_shift_en, w_frame_done, w_frame_good;

  assign w_data_bit = r_filt[1];
  assign w_timeout  = (r_state != ST_IDLE) && (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_shift_en   = 1'b0;
    w_frame_done = 1'b0;
    w_frame_good = 1'b0;
    if (w_fall) begin
      case (r_state)
        ST_IDLE:   if (!w_data_bit) w_state_nxt = ST_DATA;
        ST_DATA: begin
          w_shift_en = 1'b1;
          if (r_bit_cnt == 3'd7) w_state_nxt = ST_PARITY;
        end
        ST_PARITY: w_state_nxt = ST_STOP;
        ST_STOP: begin
          w_frame_done = 1'b1;
          w_frame_good = w_data_bit && (^{r_sreg, r_parity});
          w_state_nxt  = ST_IDLE;
        end
        default:   w_state_nxt = ST_IDLE;
      endcase
    end else if (w_timeout) begin
      // Abandon the partial frame silently.
      w_state_nxt = ST_IDLE;
    end
  end

  logic       r_byte_valid, r_parity_err;
  logic [7:0] r_byte;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_bit_cnt    <= '0;
      r_sreg       <= '0;
      r_parity     <= 1'b0;
      r_to_cnt     <= '0;
      r_byte_valid <= 1'b0;
      r_byte       <= '0;
      r_parity_err <= 1'b0;
    end else begin
      if (r_state == ST_IDLE || w_fall) r_to_cnt <= '0;
      else                               r_to_cnt <= r_to_cnt + TW'(1);

      if (r_state == ST_IDLE)  r_bit_cnt <= '0;
      else if (w_shift_en)     r_bit_cnt <= r_bit_cnt + 3'd1;

      if (w_shift_en) r_sreg <= {w_data_bit, r_sreg[7:1]};  // LSB first
      if (w_fall && r_state == ST_PARITY) r_parity <= w_data_bit;

      r_byte_valid <= w_frame_done && w_frame_good;
      r_parity_err <= w_frame_done && !w_frame_good;
      if (w_frame_done) r_byte <= r_sreg;
    end
  end

  // --------------------------------------------------------------------------
  // Decoder: prefix/shift tracking and translation
  // --------------------------------------------------------------------------
  logic       r_ext, r_brk, r_shift_held;
  logic [7:0] w_ascii;
  logic       w_is_prefix, w_is_shift, w_push_req;

  ps2_scan_to_ascii u_lookup (
    .i_scan  (r_byte),
    .i_shift (r_shift_held),
    .o_ascii (w_ascii)
  );

  assign w_is_prefix = (r_byte == SC_EXT) || (r_byte == SC_BREAK);
  assign w_is_shift  = (r_byte == SC_LSHIFT) || (r_byte == SC_RSHIFT);
  assign w_push_req  = r_byte_valid && !w_is_prefix && !w_is_shift &&
                       !r_brk && !r_ext && (w_ascii != ASCII_NUL);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ext        <= 1'b0;
      r_brk        <= 1'b0;
      r_shift_held <= 1'b0;
    end else if (r_byte_valid) begin
      if (r_byte == SC_EXT) begin
        r_ext <= 1'b1;
      end else if (r_byte == SC_BREAK) begin
        r_brk <= 1'b1;
      end else begin
        if (w_is_shift) r_shift_held <= ~r_brk;
        r_ext <= 1'b0;
        r_brk <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Key FIFO
  // --------------------------------------------------------------------------
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;
  logic          w_full, w_do_pop, w_do_push;

  assign w_full    = (r_count == CW'(FIFO_DEPTH));
  assign w_do_pop  = key_rd && (r_count != '0);
  // A pop in the same cycle frees the slot, so a push into a full queue
  // still succeeds when the CPU reads at the same time.
  assign w_do_push = w_push_req && (!w_full || w_do_pop);

  // NOTE: the storage array has no reset; the count gates every read, so stale
  // contents are never visible and the array can map to plain RAM/flops.
  always_ff @(posedge clock) begin
    if (w_do_push) r_mem[r_wr_ptr] <= w_ascii;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_push_req && !w_do_push) r_overflow <= 1'b1;
    end
  end

  assign key_valid    = (r_count != '0);
  assign bus_keyboard = key_valid ? r_mem[r_rd_ptr] : ASCII_NUL;
  assign parity_err   = r_parity_err;
  assign overflow     = r_overflow;

endmodule
